// File: rtl/encrypt_channel_arbiter.sv
// Two-requester round-robin front end that serialises each accepted word into a
// framed MSB-first bitstream (sync bit, source-id bit, data bits, idle gap).
module encrypt_channel_arbiter #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    output logic              o_data,
    output logic              o_frame,
    output logic              o_src,
    output logic              o_busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SRC,
        DATA,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               last_src_q, last_src_d;
    logic               data_q, data_d;
    logic               frame_q, frame_d;
    logic               src_q, src_d;
    logic               busy_q, busy_d;
    logic               grant0, grant1;

    // Both valid: the requester that did not win last time gets the grant.
    always_comb begin
        grant0       = i_req0_valid & (~i_req1_valid | last_src_q);
        grant1       = i_req1_valid & (~i_req0_valid | ~last_src_q);
        o_req0_ready = ~i_rst & i_enable & (state_q == IDLE) & grant0;
        o_req1_ready = ~i_rst & i_enable & (state_q == IDLE) & grant1;
    end

    // Outputs are registered from the next state, so each bit appears the
    // cycle after the edge that enters its state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        last_src_d = last_src_q;
        src_d      = src_q;
        data_d     = 1'b0;
        frame_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (o_req0_ready || o_req1_ready) begin
                    state_d    = SYNC;
                    src_d      = o_req1_ready;
                    last_src_d = o_req1_ready;
                    shift_d    = o_req1_ready ? i_req1_data : i_req0_data;
                    data_d     = 1'b1;
                    frame_d    = 1'b1;
                end
            end
            SYNC: begin
                state_d = SRC;
                data_d  = src_q;
                frame_d = 1'b1;
            end
            SRC: begin
                state_d = DATA;
                cnt_d   = '0;
                data_d  = shift_q[DATA_W-1];
                shift_d = shift_q << 1;
                frame_d = 1'b1;
            end
            DATA: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    data_d  = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                    frame_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            last_src_q <= 1'b1;
            src_q      <= 1'b0;
            data_q     <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            last_src_q <= last_src_d;
            src_q      <= src_d;
            data_q     <= data_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
        end
    end

    assign o_data  = data_q;
    assign o_frame = frame_q;
    assign o_src   = src_q;
    assign o_busy  = busy_q;

endmodule

// File: doc/encrypt_channel_arbiter.md
Name: encrypt_channel_arbiter

Overview:
Two-requester front end for the serial encrypt channel. It accepts a DATA_W-bit word from either of two byte-wide requesters using a valid/ready handshake, with round-robin arbitration. Each word is serialised MSB-first into a framed bitstream: a sync bit, a source-id bit, the data bits, then an idle gap. o_data drives the data_encrypt serial input directly.

Parameters:
DATA_W, 8, payload bits per frame (>=1)
GAP_CYCLES, 2, forced-zero idle cycles after each frame (>=0)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_enable  in  1  permits new frame starts; an in-progress frame always completes
i_req0_valid  in  1  requester 0 has a word
i_req0_data  in  DATA_W  requester 0 word
o_req0_ready  out  1  requester 0 word accepted this cycle
i_req1_valid  in  1  requester 1 has a word
i_req1_data  in  DATA_W  requester 1 word
o_req1_ready  out  1  requester 1 word accepted this cycle
o_data  out  1  serial bit to encryptor, registered
o_frame  out  1  high during sync, source-id and data bits, registered
o_src  out  1  source of current/last frame, registered
o_busy  out  1  high in any state other than IDLE, registered

Behaviour:
- Reset: state=IDLE; o_data, o_frame, o_src, o_busy = 0; shift reg = 0; bit counter = 0; last_src = 1, so requester 0 wins the first tie. Reset mid-frame aborts the frame: all outputs are 0 on the cycle after the i_rst edge, with no partial completion.
- States: IDLE -> SYNC -> SRC -> DATA -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0 (DATA -> IDLE).
- Arbitration, combinational, in IDLE only:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_src is granted.
  - Neither valid: no grant.
- o_reqN_ready = (state==IDLE) & i_enable & grant_N. The ready outputs are combinational and never both high.
- Transfer occurs when valid & ready at a clock edge. On that edge: latch data into the shift reg, latch src into o_src and last_src, go to SYNC. A requester may drop valid before ready with no side effect.
- SYNC (1 cycle): o_data=1, o_frame=1.
- SRC (1 cycle): o_data=o_src, o_frame=1.
- DATA (DATA_W cycles): o_data = shift-reg MSB, shift left each cycle, o_frame=1. The counter runs 0..DATA_W-1, width $clog2(DATA_W) with a minimum of 1.
- GAP (GAP_CYCLES cycles): o_data=0, o_frame=0.
- IDLE: o_data=0, o_frame=0; o_src holds its last value.
- Timing:
  - Handshake edge to first sync bit on o_data: 1 cycle.
  - Frame length: 2+DATA_W cycles.
  - Minimum ready-pulse spacing: 3+DATA_W+GAP_CYCLES cycles (defaults: 13).
- i_enable low in IDLE: no ready is asserted and the state stays IDLE. i_enable changes outside IDLE have no effect on the current frame.
- Simultaneous i_rst and handshake: reset wins; no transfer is recorded.
- Requester data is not required to be stable after the handshake edge.

Test Plan:
1. Hold i_rst=1 for 3 cycles with both valids high -> both readys 0; o_data, o_frame, o_busy = 0 throughout.
2. req0 only, data=0xA5 -> one o_req0_ready pulse. Next 10 cycles: o_frame=1 and o_data = 1,0, 1,0,1,0,0,1,0,1; o_src=0. Then 2 cycles of o_data=0, o_frame=0, then IDLE.
3. Both valid continuously, data0=0x0F, data1=0xF0 -> grant order 0,1,0,1. Ready pulses exactly 13 cycles apart. o_src bit inside each frame alternates 0,1,0,1.
4. Drop i_enable during DATA bit 3 with req1 pending -> current frame completes intact and no ready is asserted. Raise i_enable -> req1 is granted in the first IDLE cycle.
5. Assert i_rst at DATA bit 4 while both requesters are valid -> next cycle o_frame=0, o_data=0, o_busy=0. After release, requester 0 is granted first.
6. GAP_CYCLES=0, DATA_W=4, req0 continuously valid -> frames 6 cycles long, ready pulses every 7 cycles, o_frame low for exactly 1 cycle between frames.
